// File: rtl/pipe_adder_if.sv
// Operand/result bus for pipe_adder.
// Input side: in_valid/in_ready handshake carrying opr0, opr1, minus, plus flush.
// Output side: out_valid/out_ready handshake carrying result, ovf, zero.
// master drives operands and consumes results; slave is the adder.
interface pipe_adder_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] opr0;
  logic [WIDTH-1:0] opr1;
  logic             minus;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   result;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, opr0, opr1, minus, flush, out_ready,
    input  in_ready, out_valid, result, ovf, zero
  );

  modport slave (
    input  in_valid, opr0, opr1, minus, flush, out_ready,
    output in_ready, out_valid, result, ovf, zero
  );

endinterface

// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit, one CW = WIDTH/STAGES bit chunk per stage.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - pipe_adder_if.slave: operands in, result/ovf/zero out, flush
// Subtract is opr0 + ~opr1 + 1. Chunk k is added in stage k; its carry and
// the operand bits not yet consumed are registered into stage k+1. The last
// stage's registers are the output registers, so latency is STAGES cycles.
// A single global stall (output valid but not taken) freezes every stage.
module pipe_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input logic        clk,
  input logic        rst,
  pipe_adder_if.slave bus
);

  localparam int unsigned CW = WIDTH / STAGES;

  logic stall;
  logic accept;

  // Index k holds the inputs seen by stage k.
  logic [STAGES-1:0]            stg_v;
  logic [STAGES-1:0]            stg_m;
  logic [STAGES-1:0]            stg_c;
  logic [STAGES-1:0][WIDTH-1:0] stg_a;
  logic [STAGES-1:0][WIDTH-1:0] stg_b;
  logic [STAGES-1:0][WIDTH-1:0] stg_s;

  logic           out_valid_q;
  logic [WIDTH:0] result_q;
  logic           ovf_q;
  logic           zero_q;

  assign stall        = out_valid_q & ~bus.out_ready;
  assign bus.in_ready = ~stall & ~bus.flush;
  assign accept       = bus.in_valid & bus.in_ready;

  // Stage 0 is fed straight from the bus; b is pre-inverted for subtract and
  // the carry-in supplies the +1.
  assign stg_v[0] = accept;
  assign stg_m[0] = bus.minus;
  assign stg_c[0] = bus.minus;
  assign stg_a[0] = bus.opr0;
  assign stg_b[0] = bus.minus ? ~bus.opr1 : bus.opr1;
  assign stg_s[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CW:0]      chunk_sum;
    logic [WIDTH-1:0] sum_d;

    assign chunk_sum = {1'b0, stg_a[k][k*CW +: CW]} + {1'b0, stg_b[k][k*CW +: CW]}
                     + {{CW{1'b0}}, stg_c[k]};

    always_comb begin
      sum_d                = stg_s[k];
      sum_d[k*CW +: CW]    = chunk_sum[CW-1:0];
    end

    if (k < STAGES - 1) begin : g_mid
      logic             v_q;
      logic             m_q;
      logic             c_q;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] s_q;

      always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
          v_q <= 1'b0;
        end else if (!stall) begin
          v_q <= stg_v[k];
        end
      end

      // Datapath is don't-care while invalid, so it carries no reset.
      always_ff @(posedge clk) begin
        if (!stall) begin
          m_q <= stg_m[k];
          c_q <= chunk_sum[CW];
          a_q <= stg_a[k];
          b_q <= stg_b[k];
          s_q <= sum_d;
        end
      end

      assign stg_v[k+1] = v_q;
      assign stg_m[k+1] = m_q;
      assign stg_c[k+1] = c_q;
      assign stg_a[k+1] = a_q;
      assign stg_b[k+1] = b_q;
      assign stg_s[k+1] = s_q;
    end else begin : g_last
      logic           a_msb;
      logic           b_msb;
      logic           s_msb;
      logic [WIDTH:0] result_d;
      logic           ovf_d;
      logic           zero_d;
      logic           unused_skew;

      assign a_msb = stg_a[k][WIDTH-1];
      assign b_msb = stg_b[k][WIDTH-1];
      assign s_msb = chunk_sum[CW-1];

      // For subtract the top bit is a borrow: set when there was no carry out.
      assign result_d = {chunk_sum[CW] ^ stg_m[k], sum_d};
      assign ovf_d    = (a_msb == b_msb) && (s_msb != a_msb);
      assign zero_d   = (sum_d == '0);

      // Lower chunks of the skewed operands are already consumed here.
      assign unused_skew = ^{stg_a[k], stg_b[k]};

      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid_q <= 1'b0;
          result_q    <= '0;
          ovf_q       <= 1'b0;
          zero_q      <= 1'b0;
        end else begin
          if (bus.flush) begin
            out_valid_q <= 1'b0;
          end else if (!stall) begin
            out_valid_q <= stg_v[k];
          end
          if (!stall) begin
            result_q <= result_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
          end
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder: three instances (32/4, 8/1, 64/8).
// Outputs are sampled 2 time units after the rising edge; inputs change 1
// unit after it. Expected values come from hand constants or a plain
// full-width arithmetic model.
module tb_pipe_adder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipe_adder_if #(.WIDTH(32)) b32 ();
  pipe_adder_if #(.WIDTH(8))  b8  ();
  pipe_adder_if #(.WIDTH(64)) b64 ();

  pipe_adder #(.WIDTH(32), .STAGES(4)) u_dut32 (.clk(clk), .rst(rst), .bus(b32));
  pipe_adder #(.WIDTH(8),  .STAGES(1)) u_dut8  (.clk(clk), .rst(rst), .bus(b8));
  pipe_adder #(.WIDTH(64), .STAGES(8)) u_dut64 (.clk(clk), .rst(rst), .bus(b64));

  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] wmask(input int w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [66:0] pack(input logic o, input logic z, input logic [64:0] r);
    return {o, z, r};
  endfunction

  // Reference: plain (W+1)-bit add/sub and sign-rule overflow.
  function automatic logic [66:0] model(input int w, input logic [63:0] a,
                                        input logic [63:0] b, input logic m);
    logic [64:0] aa, bb, r, rmask;
    logic sa, sb, sr, o, z;
    aa    = {1'b0, a};
    bb    = {1'b0, b};
    rmask = {wmask(w), 1'b1};
    r     = (m ? aa - bb : aa + bb) & rmask;
    sa    = a[w-1];
    sb    = b[w-1];
    sr    = r[w-1];
    o     = m ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    z     = ((r[63:0] & wmask(w)) == 64'd0);
    return {o, z, r};
  endfunction

  task automatic set_in(input int which, input logic v, input logic [63:0] a,
                        input logic [63:0] b, input logic m, input logic fl,
                        input logic ordy);
    case (which)
      0: begin
        b32.in_valid = v; b32.opr0 = a[31:0]; b32.opr1 = b[31:0];
        b32.minus = m; b32.flush = fl; b32.out_ready = ordy;
      end
      1: begin
        b8.in_valid = v; b8.opr0 = a[7:0]; b8.opr1 = b[7:0];
        b8.minus = m; b8.flush = fl; b8.out_ready = ordy;
      end
      default: begin
        b64.in_valid = v; b64.opr0 = a; b64.opr1 = b;
        b64.minus = m; b64.flush = fl; b64.out_ready = ordy;
      end
    endcase
  endtask

  task automatic get_out(input int which, output logic ov, output logic [66:0] pk,
                         output logic ir);
    case (which)
      0: begin
        ov = b32.out_valid; pk = {b32.ovf, b32.zero, 32'd0, b32.result}; ir = b32.in_ready;
      end
      1: begin
        ov = b8.out_valid; pk = {b8.ovf, b8.zero, 56'd0, b8.result}; ir = b8.in_ready;
      end
      default: begin
        ov = b64.out_valid; pk = {b64.ovf, b64.zero, b64.result}; ir = b64.in_ready;
      end
    endcase
  endtask

  // One isolated operation: checks acceptance, latency in cycles, and output.
  task automatic op(input int which, input int stg, input logic [63:0] a,
                    input logic [63:0] b, input logic m, input logic [66:0] exp,
                    input string tag);
    logic ov, ir;
    logic [66:0] pk;
    int lat;
    set_in(which, 1'b1, a, b, m, 1'b0, 1'b1);
    #1;
    get_out(which, ov, pk, ir);
    chk({tag, "_rdy"}, 67'(ir), 67'd1);
    tick();
    set_in(which, 1'b0, a, b, m, 1'b0, 1'b1);
    #1;
    get_out(which, ov, pk, ir);
    lat = 1;
    while (!ov && lat < 40) begin
      tick();
      lat++;
      #1;
      get_out(which, ov, pk, ir);
    end
    chk({tag, "_lat"}, 67'(lat), 67'(stg));
    chk({tag, "_res"}, pk, exp);
    tick();
  endtask

  // Back-to-back stream with an optional out_ready=0 window; scoreboard order
  // check, stability while stalled, and total cycle count (throughput).
  task automatic run_stream(input int which, input int w, input int stg, input int n,
                            input int hold_at, input int hold_len, input string tag);
    logic [66:0] eq[$];
    logic [63:0] a, b;
    logic m, ordy, ov, ir, prev_stall;
    logic [66:0] pk, prev_pk, exp;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_pk = '0;
    a = {$urandom, $urandom} & wmask(w);
    b = {$urandom, $urandom} & wmask(w);
    m = 1'($urandom_range(0, 1));
    while ((sent < n || eq.size() != 0) && cyc < 1000) begin
      ordy = !(cyc >= hold_at && cyc < hold_at + hold_len);
      set_in(which, sent < n, a, b, m, 1'b0, ordy);
      #1;
      get_out(which, ov, pk, ir);
      if (ov && !ordy) begin
        chk({tag, "_hold_rdy"}, 67'(ir), 67'd0);
        if (prev_stall) chk({tag, "_hold_out"}, pk, prev_pk);
      end
      prev_stall = ov && !ordy;
      prev_pk    = pk;
      if (ov && ordy) begin
        if (eq.size() == 0) begin
          chk({tag, "_extra"}, 67'(ov), 67'd0);
        end else begin
          exp = eq.pop_front();
          chk({tag, "_out"}, pk, exp);
          got++;
        end
      end
      if (sent < n && ir) begin
        eq.push_back(model(w, a, b, m));
        sent++;
        a = {$urandom, $urandom} & wmask(w);
        b = {$urandom, $urandom} & wmask(w);
        m = 1'($urandom_range(0, 1));
      end
      tick();
      cyc++;
    end
    chk({tag, "_count"}, 67'(got), 67'(n));
    chk({tag, "_cycles"}, 67'(cyc), 67'(n + stg + hold_len));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic ov, ir;
    logic [66:0] pk;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) set_in(i, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      get_out(i, ov, pk, ir);
      chk($sformatf("rst%0d_ov", i), 67'(ov), 67'd0);
      chk($sformatf("rst%0d_out", i), pk, 67'd0);
      chk($sformatf("rst%0d_rdy", i), 67'(ir), 67'd1);
    end
    tick();

    // 32-bit, 4 stages
    op(0, 4, 64'hFFFF_FFFF, 64'd1, 1'b0, pack(1'b0, 1'b1, 65'h1_0000_0000), "add_wrap");
    op(0, 4, 64'd5, 64'd7, 1'b1, pack(1'b0, 1'b0, 65'h1_FFFF_FFFE), "sub_neg");
    op(0, 4, 64'h8000_0000, 64'd1, 1'b1, pack(1'b1, 1'b0, 65'h0_7FFF_FFFF), "sub_ovf");
    op(0, 4, 64'h7FFF_FFFF, 64'd1, 1'b0, pack(1'b1, 1'b0, 65'h0_8000_0000), "add_ovf");

    // 8-bit, 1 stage
    op(1, 1, 64'h7F, 64'h01, 1'b0, pack(1'b1, 1'b0, 65'h080), "w8_add_ovf");
    op(1, 1, 64'h00, 64'h01, 1'b1, pack(1'b0, 1'b0, 65'h1FF), "w8_sub_borrow");
    op(1, 1, 64'hFF, 64'h01, 1'b0, pack(1'b0, 1'b1, 65'h100), "w8_add_zero");
    op(1, 1, 64'h80, 64'h01, 1'b1, pack(1'b1, 1'b0, 65'h07F), "w8_sub_ovf");

    // 64-bit, 8 stages
    op(2, 8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
       pack(1'b0, 1'b1, 65'h1_0000_0000_0000_0000), "w64_add_wrap");
    op(2, 8, 64'h8000_0000_0000_0000, 64'd1, 1'b1,
       pack(1'b1, 1'b0, 65'h0_7FFF_FFFF_FFFF_FFFF), "w64_sub_ovf");
    op(2, 8, 64'd3, 64'd3, 1'b1, pack(1'b0, 1'b1, 65'h0), "w64_sub_eq");

    run_stream(0, 32, 4, 20, 1000, 0, "s32");
    run_stream(0, 32, 4, 24, 7, 6, "bp32");
    run_stream(1, 8, 1, 200, 1000, 0, "s8");
    run_stream(1, 8, 1, 30, 5, 6, "bp8");
    run_stream(2, 64, 8, 40, 10, 6, "s64");

    // Flush with three operations in flight, plus a discarded input.
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1'b1, 64'(i + 10), 64'(i + 1), 1'b0, 1'b0, 1'b1);
      tick();
    end
    set_in(0, 1'b1, 64'd99, 64'd1, 1'b0, 1'b1, 1'b1);
    #1;
    get_out(0, ov, pk, ir);
    chk("flush_rdy", 67'(ir), 67'd0);
    tick();
    set_in(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    #1;
    get_out(0, ov, pk, ir);
    chk("flush_ov", 67'(ov), 67'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      #1;
      get_out(0, ov, pk, ir);
      chk("flush_quiet", 67'(ov), 67'd0);
    end
    tick();
    op(0, 4, 64'h1234_5678, 64'h1111_1111, 1'b0, pack(1'b0, 1'b0, 65'h0_2345_6789),
       "post_flush");

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1'b1, 64'(i + 20), 64'(i + 2), 1'b1, 1'b0, 1'b1);
      tick();
    end
    rst = 1'b1;
    set_in(0, 1'b1, 64'd55, 64'd5, 1'b0, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    set_in(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    #1;
    get_out(0, ov, pk, ir);
    chk("rst_mid_ov", 67'(ov), 67'd0);
    chk("rst_mid_out", pk, 67'd0);
    chk("rst_mid_rdy", 67'(ir), 67'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      #1;
      get_out(0, ov, pk, ir);
      chk("rst_quiet", 67'(ov), 67'd0);
    end
    tick();
    op(0, 4, 64'h8000_0000, 64'h8000_0000, 1'b0, pack(1'b1, 1'b1, 65'h1_0000_0000),
       "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
